// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-serial memory initiator. Accepts one byte/halfword/word
//            load or store, sequences it as little-endian single-byte
//            accesses on an 8-bit memory port and returns an extended load
//            result together with a one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        mem_rw,
    output logic [7:0]  mem_write,
    input  logic [7:0]  mem_read,
    output logic [31:0] mem_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        lat_we;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  byte_idx;
    logic [1:0]  last_idx;
    logic [31:0] load_buf;

    logic        accept;
    logic        xfer_done;
    logic [31:0] load_buf_next;
    logic [31:0] load_result;
    logic [7:0]  wdata_byte;

    assign accept    = (state == IDLE) && req_valid;
    assign xfer_done = (state == XFER) && (byte_idx == last_idx);

    // State register; async reset abandons any transfer in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: one cycle per byte, then a single response cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = XFER;
            XFER:    if (byte_idx == last_idx) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Merge the byte currently on the read bus into its lane.
    always_comb begin
        load_buf_next = load_buf;
        case (byte_idx)
            2'd0:    load_buf_next[7:0]   = mem_read;
            2'd1:    load_buf_next[15:8]  = mem_read;
            2'd2:    load_buf_next[23:16] = mem_read;
            default: load_buf_next[31:24] = mem_read;
        endcase
    end

    // Sign/zero extension of the assembled load data; size 11 acts as word.
    always_comb begin
        load_result = load_buf_next;
        case (lat_size)
            2'b00:   load_result = {{24{lat_signed & load_buf_next[7]}},  load_buf_next[7:0]};
            2'b01:   load_result = {{16{lat_signed & load_buf_next[15]}}, load_buf_next[15:0]};
            default: load_result = load_buf_next;
        endcase
    end

    // Request latch, byte counter and load assembly buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            byte_idx   <= 2'd0;
            last_idx   <= 2'd0;
            load_buf   <= 32'd0;
        end else if (accept) begin
            lat_we     <= req_we;
            lat_signed <= req_signed;
            lat_size   <= req_size;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            byte_idx   <= 2'd0;
            case (req_size)
                2'b00:   last_idx <= 2'd0;
                2'b01:   last_idx <= 2'd1;
                default: last_idx <= 2'd3;
            endcase
        end else if (state == XFER) begin
            byte_idx <= byte_idx + 2'd1;
            if (!lat_we) begin
                load_buf <= load_buf_next;
            end
        end
    end

    // Load result register; only a completing load updates it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_rdata <= 32'd0;
        end else if (xfer_done && !lat_we) begin
            resp_rdata <= load_result;
        end
    end

    // Store byte selection, little-endian.
    always_comb begin
        wdata_byte = 8'd0;
        case (byte_idx)
            2'd0:    wdata_byte = lat_wdata[7:0];
            2'd1:    wdata_byte = lat_wdata[15:8];
            2'd2:    wdata_byte = lat_wdata[23:16];
            default: wdata_byte = lat_wdata[31:24];
        endcase
    end

    // Memory port and handshake outputs decode directly from state so that
    // reset removes a pending write strobe without waiting for an edge.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_rw     = 1'b0;
        mem_write  = 8'd0;
        mem_addr   = 32'd0;
        if (state == XFER) begin
            mem_addr = lat_addr + {30'd0, byte_idx};
            if (lat_we) begin
                mem_rw    = 1'b1;
                mem_write = wdata_byte;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Self-checking bench for mem_ctrl with a byte memory on the port
//            and an address-indexed reference memory for expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_rw;
    logic [7:0]  mem_write;
    logic [7:0]  mem_read;
    logic [31:0] mem_addr;

    int tests = 0;
    int fails = 0;

    logic [7:0]  bus_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] exp_rdata;
    int          resp_seen;

    mem_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_rw     (mem_rw),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return def_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return def_byte(a);
    endfunction

    // Memory port: write on rising edge, read data refreshed mid-cycle.
    always @(posedge clock) begin
        if (mem_rw) bus_mem[mem_addr] = mem_write;
    end
    always @(negedge clock) begin
        mem_read = bus_rd(mem_addr);
    end

    always @(posedge clock) begin
        if (resp_valid) resp_seen = resp_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Runs one request from an IDLE cycle (posedge+1) back to the next IDLE cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        logic [63:0] val;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            val = 64'd0;
            for (int i = 0; i < n; i++) val = val + (64'(ref_rd(addr + i)) << (8*i));
            if (sgn && n < 4 && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
            exp_rdata = val[31:0];
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clock); #1;
        req_valid  = 1'b0;
        req_we     = $urandom_range(0, 1);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int k = 0; k < n; k++) begin
            check("xfer_addr",  mem_addr, addr + k);
            check("xfer_rw",    {31'd0, mem_rw}, {31'd0, we});
            check("xfer_wdata", {24'd0, mem_write}, we ? {24'd0, wdata[8*k +: 8]} : 32'd0);
            check("xfer_ready", {31'd0, req_ready}, 32'd0);
            check("xfer_resp",  {31'd0, resp_valid}, 32'd0);
            @(posedge clock); #1;
        end
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_ready", {31'd0, req_ready}, 32'd0);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_bus",   mem_addr, 32'd0);
        @(posedge clock); #1;
        check("post_resp",  {31'd0, resp_valid}, 32'd0);
        check("post_ready", {31'd0, req_ready}, 32'd1);
        if (we) begin
            for (int i = 0; i < n; i++) check("store_mem", {24'd0, bus_rd(addr + i)}, {24'd0, ref_rd(addr + i)});
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        resp_seen  = 0;
        exp_rdata  = 32'd0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_read   = 8'd0;
        bus_mem[100] = 8'h66; ref_mem[100] = 8'h66;
        bus_mem[101] = 8'hDB; ref_mem[101] = 8'hDB;
        bus_mem[102] = 8'hFF; ref_mem[102] = 8'hFF;
        bus_mem[103] = 8'h55; ref_mem[103] = 8'h55;

        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp",  {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_rw",    {31'd0, mem_rw}, 32'd0);
        check("rst_wdata", {24'd0, mem_write}, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed loads from the reference pattern.
        do_req(1'b0, 2'b10, 1'b0, 32'd100, 32'd0);
        check("word_100", resp_rdata, 32'h55FFDB66);
        do_req(1'b0, 2'b00, 1'b1, 32'd101, 32'd0);
        check("sbyte_101", resp_rdata, 32'hFFFFFFDB);
        do_req(1'b0, 2'b00, 1'b0, 32'd101, 32'd0);
        check("ubyte_101", resp_rdata, 32'h000000DB);
        do_req(1'b0, 2'b01, 1'b1, 32'd102, 32'd0);
        check("shalf_102", resp_rdata, 32'h000055FF);
        do_req(1'b0, 2'b01, 1'b1, 32'd100, 32'd0);
        check("shalf_100", resp_rdata, 32'hFFFFDB66);
        do_req(1'b0, 2'b11, 1'b1, 32'd100, 32'd0);
        check("size11_word", resp_rdata, 32'h55FFDB66);

        // Store then reload; store response must leave resp_rdata alone.
        do_req(1'b1, 2'b10, 1'b0, 32'd200, 32'h11223344);
        check("store_keep", resp_rdata, 32'h55FFDB66);
        do_req(1'b0, 2'b10, 1'b0, 32'd200, 32'd0);
        check("reload_200", resp_rdata, 32'h11223344);

        // Address wrap.
        do_req(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'd0);
        check("wrap_half", resp_rdata, {16'd0, def_byte(32'd0), def_byte(32'hFFFFFFFF)});

        // Reset after two store bytes: strobe drops asynchronously.
        resp_seen = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr  = 32'd200; req_wdata = 32'hA1B2C3D4;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_rst_rw", {31'd0, mem_rw}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rw",    {31'd0, mem_rw}, 32'd0);
        check("async_addr",  mem_addr, 32'd0);
        check("async_ready", {31'd0, req_ready}, 32'd1);
        check("async_rdata", resp_rdata, 32'd0);
        ref_mem[200] = 8'hD4;
        ref_mem[201] = 8'hC3;
        exp_rdata = 32'd0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) check("rst_mem", {24'd0, bus_rd(32'd200 + i)}, {24'd0, ref_rd(32'd200 + i)});
        check("rst_no_resp", resp_seen, 0);
        check("rst_ready2", {31'd0, req_ready}, 32'd1);

        // Continuous valid: one acceptance every 3 cycles.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b1;
        req_addr  = 32'd101;
        exp_rdata = 32'hFFFFFFDB;
        @(posedge clock); #1;
        for (int i = 0; i < 9; i++) begin
            check("b2b_ready", {31'd0, req_ready}, (i % 3 == 2) ? 32'd1 : 32'd0);
            check("b2b_resp",  {31'd0, resp_valid}, (i % 3 == 1) ? 32'd1 : 32'd0);
            check("b2b_addr",  mem_addr, (i % 3 == 0) ? 32'd101 : 32'd0);
            if (i % 3 == 1) check("b2b_rdata", resp_rdata, exp_rdata);
            if (i < 8) begin
                @(posedge clock); #1;
            end
        end
        req_valid = 1'b0;
        @(posedge clock); #1;
        check("b2b_end", {31'd0, req_ready}, 32'd1);

        // Randomized mix against the reference memory.
        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 7);
            else                           a = 32'd300 + $urandom_range(0, 31);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
